// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter: default line
// timing, data width and the receiver state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BAUD_DEF     = 9600;
    localparam int DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_baud_timer.sv
// -----------------------------------------------------------------------------
// uart_baud_timer
// Loadable down-counter with a zero flag. A load of N-1 makes zero_o assert
// N cycles later, so a phase started by a load lasts exactly N cycles.
// The counter parks at zero until the next load.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset (counter -> 0)
//   load_i      load load_val_i on the next rising edge (priority over count)
//   load_val_i  value to load (phase length minus one)
//   zero_o      high while the counter reads zero
// -----------------------------------------------------------------------------
module uart_baud_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The serial line is brought into the clock domain by a
// two-flop synchroniser, the start bit is qualified at its mid-point and every
// following bit is sampled one bit time later, i.e. at its own mid-point.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx_in       serial line, asynchronous, idle high
//   data        last correctly framed byte (held until the next good frame)
//   data_valid  one-cycle pulse when data updates
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    generate
        if (BIT_CYCLES < 4) begin : g_bit_cycles_check
            $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    // Synchroniser flops reset to 1 so a reset does not look like a start edge.
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    uart_baud_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = BIT_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tmr_zero) begin
                    if (!rx_s) begin
                        tmr_load  = 1'b1;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tmr_zero) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    tmr_load  = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tmr_zero) begin
                    if (rx_s) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line is released so a break gives one error.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // The shift register is fully rewritten by every frame before it is used.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_in;
    logic       rx_def;
    logic [7:0] data, data_def;
    logic       dv, fe, busy;
    logic       dv_def, fe_def, busy_def;

    uart_rx #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data       (data),
        .data_valid (dv),
        .frame_err  (fe),
        .busy       (busy)
    );

    uart_rx dut_def (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_def),
        .data       (data_def),
        .data_valid (dv_def),
        .frame_err  (fe_def),
        .busy       (busy_def)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        bit         busy;
        int         at;
    } exp_t;

    exp_t q_s[$];
    exp_t q_d[$];
    exp_t e_s, e_d;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [9:0] frame(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b0};
    endfunction

    // Must be entered at a negedge; returns at a negedge so frames abut.
    task automatic send(input bit sel, input logic [9:0] bits, input int nslots, input int bc);
        for (int i = 0; i < nslots; i++) begin
            if (sel) rx_def = bits[i];
            else     rx_in  = bits[i];
            repeat (bc) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_s(input bit is_err, input logic [7:0] d, input bit b, input int at);
        exp_t e;
        e.is_err = is_err; e.d = d; e.busy = b; e.at = at;
        q_s.push_back(e);
    endtask

    // Monitor for the small-parameter instance.
    always @(negedge clk) begin
        if (!rst && (dv || fe)) begin
            check("exclusive_strobes", 32'(dv & fe), 32'd0);
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got dv=%0b fe=%0b data=%0h, expected no strobe (cycle %0d)",
                         dv, fe, data, cyc);
            end else begin
                e_s = q_s.pop_front();
                check("strobe_kind_fe", 32'(fe), 32'(e_s.is_err));
                check("data", 32'(data), 32'(e_s.d));
                check("busy_at_strobe", 32'(busy), 32'(e_s.busy));
                if (e_s.at >= 0) check("strobe_time", 32'(cyc), 32'(e_s.at));
            end
        end
    end

    // Monitor for the default-parameter instance.
    always @(negedge clk) begin
        if (!rst && (dv_def || fe_def)) begin
            if (q_d.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe_def: got dv=%0b fe=%0b data=%0h, expected no strobe",
                         dv_def, fe_def, data_def);
            end else begin
                e_d = q_d.pop_front();
                check("def_kind_fe", 32'(fe_def), 32'(e_d.is_err));
                check("def_data", 32'(data_def), 32'(e_d.d));
                check("def_time", 32'(cyc), 32'(e_d.at));
            end
        end
    end

    initial begin
        exp_t ed;
        rst    = 1'b1;
        rx_in  = 1'b1;
        rx_def = 1'b1;
        idle(3);
        check("rst_data", 32'(data), 32'h0);
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_fe", 32'(fe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_data_def", 32'(data_def), 32'h0);
        rst = 1'b0;
        idle(2);

        // 0xA5: valid 155 cycles after the first line drive (2 sync + 8 + 144 + 1).
        expect_s(1'b0, 8'hA5, 1'b0, cyc + 155);
        send(1'b0, frame(8'hA5, 1'b1), 10, 16);
        idle(4);

        // Back-to-back frames, no idle gap.
        expect_s(1'b0, 8'h00, 1'b0, cyc + 155);
        expect_s(1'b0, 8'hFF, 1'b0, cyc + 160 + 155);
        send(1'b0, frame(8'h00, 1'b1), 10, 16);
        send(1'b0, frame(8'hFF, 1'b1), 10, 16);
        idle(4);

        // Short low glitch: enters START, returns to IDLE with no strobe.
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        check("glitch_busy_in_start", 32'(busy), 32'h1);
        idle(20);
        check("glitch_busy_after", 32'(busy), 32'h0);
        check("glitch_data_kept", 32'(data), 32'hFF);

        // Stop bit low followed by a break: one frame_err, data kept.
        expect_s(1'b1, 8'hFF, 1'b1, cyc + 155);
        send(1'b0, frame(8'h3C, 1'b0), 10, 16);
        idle(100);
        check("break_busy_held", 32'(busy), 32'h1);
        check("break_data_kept", 32'(data), 32'hFF);
        rx_in = 1'b1;
        idle(4);
        check("break_busy_released", 32'(busy), 32'h0);

        // Reset during data bit 4, then a clean frame.
        send(1'b0, frame(8'h12, 1'b1), 5, 16);
        rx_in = 1'b0;
        idle(8);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_dv", 32'(dv), 32'h0);
        check("midrst_fe", 32'(fe), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        rx_in = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(20);
        expect_s(1'b0, 8'h5A, 1'b0, cyc + 155);
        send(1'b0, frame(8'h5A, 1'b1), 10, 16);
        for (int i = 0; i < 200 && q_s.size() != 0; i++) @(negedge clk);
        check("small_queue_drained", 32'(q_s.size()), 32'd0);

        // Default timing: 5208 cycles/bit, valid at 2 + 2604 + 9*5208 + 1.
        ed.is_err = 1'b0; ed.d = 8'h55; ed.busy = 1'b0; ed.at = cyc + 49479;
        q_d.push_back(ed);
        send(1'b1, frame(8'h55, 1'b1), 10, 5208);
        for (int i = 0; i < 200 && q_d.size() != 0; i++) @(negedge clk);
        check("def_queue_drained", 32'(q_d.size()), 32'd0);
        check("def_busy_idle", 32'(busy_def), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
